// File: rtl/perm3_pkg.sv
// rtl/perm3_pkg.sv - shared types, sizes and default tables for the perm3 decoder
package perm3_pkg;

  localparam int W = 3;
  localparam int N = 1 << W;

  typedef enum logic [1:0] {
    RUN,
    CLEAR,
    BUILD
  } state_t;

  // Packed with entry 0 in the low bits: fwd 0->7,1->6,2->4,3->5,4->1,5->0,6->2,7->3
  localparam logic [23:0] FWD3 = {3'd3, 3'd2, 3'd0, 3'd1, 3'd5, 3'd4, 3'd6, 3'd7};
  localparam logic [23:0] INV3 = {3'd0, 3'd1, 3'd3, 3'd2, 3'd7, 3'd6, 3'd4, 3'd5};

  function automatic logic [W-1:0] dflt_fwd(input int i);
    if (W == 3) return W'(FWD3[i*3 +: 3]);
    return W'(i);
  endfunction

  function automatic logic [W-1:0] dflt_inv(input int i);
    if (W == 3) return W'(INV3[i*3 +: 3]);
    return W'(i);
  endfunction

endpackage

// File: rtl/perm3_if.sv
// rtl/perm3_if.sv - code-word input stream and decoded output stream
interface perm3_if;
  import perm3_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_code;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_err;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

endinterface

// File: rtl/perm3_inv_builder.sv
// rtl/perm3_inv_builder.sv - rebuilds the inverse table from the forward table
// and flags any forward value hit twice.
module perm3_inv_builder
  import perm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         restart,
  input  logic [W-1:0] fwd_val,
  output logic [W-1:0] idx,
  input  logic [W-1:0] lk_code,
  output logic [W-1:0] lk_data,
  output logic         lk_vld,
  output logic         busy,
  output logic         ok
);

  state_t       state;
  logic         dup;
  logic [W-1:0] inv [N];
  logic [N-1:0] inv_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      idx     <= '0;
      dup     <= 1'b0;
      ok      <= 1'b1;
      busy    <= 1'b0;
      inv_vld <= '1;
      for (int i = 0; i < N; i++) inv[i] <= dflt_inv(i);
    end else if (restart) begin
      // A write at any point invalidates the partial inverse; start over.
      state <= CLEAR;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          inv_vld <= '0;
          dup     <= 1'b0;
          idx     <= '0;
          state   <= BUILD;
        end
        BUILD: begin
          if (inv_vld[fwd_val]) begin
            dup <= 1'b1;
          end else begin
            inv[fwd_val]     <= idx;
            inv_vld[fwd_val] <= 1'b1;
          end
          if (idx == W'(N - 1)) begin
            state <= RUN;
            busy  <= 1'b0;
            ok    <= !(dup || inv_vld[fwd_val]);
            idx   <= '0;
          end else begin
            idx <= idx + W'(1);
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign lk_data = inv[lk_code];
  assign lk_vld  = inv_vld[lk_code];

endmodule

// File: rtl/perm3_decoder.sv
// rtl/perm3_decoder.sv - streaming inverse of the perm3 encoder with a
// run-time-loadable forward table and 1-deep registered output.
module perm3_decoder
  import perm3_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  perm3_if.slave       bus,
  input  logic         tbl_wr_en,
  input  logic [W-1:0] tbl_wr_addr,
  input  logic [W-1:0] tbl_wr_data,
  output logic         tbl_busy,
  output logic         tbl_ok
);

  logic [W-1:0] fwd [N];
  logic [W-1:0] idx;
  logic [W-1:0] lk_data;
  logic         lk_vld;
  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic         out_err_q;
  logic         xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) fwd[i] <= dflt_fwd(i);
    end else if (tbl_wr_en) begin
      fwd[tbl_wr_addr] <= tbl_wr_data;
    end
  end

  perm3_inv_builder u_builder (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (tbl_wr_en),
    .fwd_val (fwd[idx]),
    .idx     (idx),
    .lk_code (bus.in_code),
    .lk_data (lk_data),
    .lk_vld  (lk_vld),
    .busy    (tbl_busy),
    .ok      (tbl_ok)
  );

  assign bus.in_ready = !tbl_busy && !tbl_wr_en && (!out_valid_q || bus.out_ready);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= lk_vld ? lk_data : '0;
      out_err_q   <= !lk_vld;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_perm3_decoder.sv
// tb/tb_perm3_decoder.sv - scoreboard bench for perm3_decoder
module tb_perm3_decoder;
  import perm3_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tbl_wr_en;
  logic [W-1:0] tbl_wr_addr;
  logic [W-1:0] tbl_wr_data;
  logic         tbl_busy;
  logic         tbl_ok;

  int           n_vec = 0;
  int           n_bad = 0;
  logic [W:0]   q [$];
  int           blen;

  always #5 clk = ~clk;

  perm3_if bus ();

  perm3_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
    .tbl_busy    (tbl_busy),
    .tbl_ok      (tbl_ok)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is checked against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL sb_unexpected: got err=%0d data=%0d with nothing expected",
                 bus.out_err, bus.out_data);
      end else begin
        chk("sb_word {err,data}", int'({bus.out_err, bus.out_data}), int'(q.pop_front()));
      end
    end
  end

  task automatic send(input logic [W-1:0] c, input logic [W:0] e, input bit push = 1'b1);
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    if (push) q.push_back(e);
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (k > 60) begin
        n_vec++;
        n_bad++;
        $display("FAIL send_timeout: code %0d never accepted", c);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wr(input logic [W-1:0] a, input logic [W-1:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = a;
    tbl_wr_data = d;
    @(posedge clk);
    #1;
    tbl_wr_en = 1'b0;
  endtask

  task automatic busy_len(output int n, input bit chk_rdy);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!tbl_busy) break;
      n++;
      if (chk_rdy) chk("in_ready_busy", int'(bus.in_ready), 0);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 50; k++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench stalled");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b1;
    tbl_wr_en     = 1'b0;
    tbl_wr_addr   = '0;
    tbl_wr_data   = '0;

    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_out_err", int'(bus.out_err), 0);
    chk("rst_tbl_busy", int'(tbl_busy), 0);
    chk("rst_tbl_ok", int'(tbl_ok), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", int'(bus.in_ready), 1);

    // Default table, back-to-back
    send(3'd7, 4'h0); send(3'd6, 4'h1); send(3'd4, 4'h2); send(3'd5, 4'h3);
    send(3'd1, 4'h4); send(3'd0, 4'h5); send(3'd2, 4'h6); send(3'd3, 4'h7);
    drain();
    chk("dflt_tbl_ok", int'(tbl_ok), 1);

    // Output stall: code 4 held while downstream is not ready
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3'd4, 4'h2);
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_out_data", int'(bus.out_data), 2);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(3'd7, 4'h0);
    drain();

    // Duplicate forward value: fwd[5]=7 collides with fwd[0]
    @(posedge clk);
    #1;
    wr(3'd5, 3'd7);
    busy_len(blen, 1'b0);
    chk("dup_busy_len", blen, 9);
    chk("dup_tbl_ok", int'(tbl_ok), 0);
    @(posedge clk);
    #1;
    send(3'd0, 4'h8);
    send(3'd7, 4'h0);
    drain();

    // Repair the table
    @(posedge clk);
    #1;
    wr(3'd5, 3'd0);
    busy_len(blen, 1'b0);
    chk("fix_busy_len", blen, 9);
    chk("fix_tbl_ok", int'(tbl_ok), 1);
    @(posedge clk);
    #1;
    send(3'd0, 4'h5);
    drain();

    // Second write lands at BUILD idx 4 while a word waits upstream
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd3;
    q.push_back(4'h7);
    wr(3'd6, 3'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("restart_in_ready", int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
    end
    wr(3'd6, 3'd2);
    busy_len(blen, 1'b1);
    chk("restart_busy_len", blen, 9);
    chk("restart_ready_after", int'(bus.in_ready), 1);
    chk("restart_tbl_ok", int'(tbl_ok), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    drain();

    // Reset in the middle of a build with a word parked at the output
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3'd1, 4'h4, 1'b0);
    wr(3'd0, 3'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_tbl_busy", int'(tbl_busy), 0);
    chk("midrst_tbl_ok", int'(tbl_ok), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(3'd3, 4'h7);
    drain();
    // A rebuild from the restored forward table must still be a bijection
    @(posedge clk);
    #1;
    wr(3'd7, 3'd3);
    busy_len(blen, 1'b0);
    chk("post_rst_busy_len", blen, 9);
    chk("post_rst_tbl_ok", int'(tbl_ok), 1);
    @(posedge clk);
    #1;
    send(3'd0, 4'h5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/perm3_decoder.md
Name: perm3_decoder

Overview:
- Streaming inverse of the team's 3-in/3-out permutation truth-table encoder: takes an encoded code word and returns the original input.
- Holds a run-time-loadable forward table. A small FSM rebuilds the inverse table after every table write and checks the table is a bijection.
- Sits downstream of the encoder, behind a valid/ready stream interface, with a 1-deep registered output.

Parameters:
- W, 3, data/code width; table depth N = 2^W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  code word present.
- in_ready  out  1  decoder accepts a code word this cycle.
- in_code  in  W  encoded word; for W=3, bit2=out1, bit1=out2, bit0=out3 of the encoder.
- out_valid  out  1  decoded word present.
- out_ready  in  1  downstream accepts.
- out_data  out  W  decoded input; for W=3, bit2=in3, bit1=in2, bit0=in1.
- out_err  out  1  in_code had no preimage in the current table.
- tbl_wr_en  in  1  write one forward-table entry.
- tbl_wr_addr  in  W  forward index (encoder input).
- tbl_wr_data  in  W  forward value (encoder output code).
- tbl_busy  out  1  inverse rebuild in progress.
- tbl_ok  out  1  last completed build found a bijection.

Behaviour:
- Reset (async, rst_n=0) sets:
  - fwd table for W=3 to 0->7, 1->6, 2->4, 3->5, 4->1, 5->0, 6->2, 7->3; identity for other W.
  - inv table to the matching inverse; for W=3: 0->5, 1->4, 2->6, 3->7, 4->2, 5->3, 6->1, 7->0.
  - inv_vld all 1, tbl_ok=1, tbl_busy=0, out_valid=0, out_data=0, out_err=0, state RUN, build index 0.
- FSM states RUN, CLEAR, BUILD.
  - RUN: tbl_wr_en writes fwd[tbl_wr_addr], then next state is CLEAR.
  - CLEAR: one cycle. Clears all inv_vld bits and the dup flag, sets idx=0.
  - BUILD: one entry per cycle, idx 0..N-1, with f=fwd[idx]:
    - if inv_vld[f] is already set: dup=1, first mapping kept;
    - else: inv[f]=idx and inv_vld[f]=1.
  - After idx=N-1: next state is RUN, and tbl_ok=!dup (including the last entry's result).
- Rebuild latency: N+1 cycles from the write cycle to RUN; 9 cycles for W=3.
- tbl_busy=1 in CLEAR and BUILD.
- tbl_wr_en during CLEAR or BUILD: entry written, FSM restarts at CLEAR next cycle.
- tbl_ok holds its old value until a build completes.
- Handshake:
  - in_ready = (state==RUN) && !tbl_wr_en && (!out_valid || out_ready).
  - Transfer when in_valid && in_ready.
  - On transfer, next cycle: out_valid=1, out_data=inv[in_code], out_err=!inv_vld[in_code]; out_data=0 when out_err=1.
  - Latency 1 cycle. Full throughput when out_ready is held high.
- out_valid && !out_ready: out_valid, out_data and out_err stay stable.
- Output handshake done and no new transfer: out_valid falls to 0.
- Simultaneous output pop and input accept: new word loaded, out_valid stays 1.
- tbl_wr_en in RUN with in_valid high: no transfer that cycle.
- A word already in the output register keeps its decode after a table change.
- Reset mid-build aborts the build and restores the reset tables.
- in_valid must not depend on in_ready.

Decomposition:
- Package perm3_pkg holds:
  - state enum (RUN, CLEAR, BUILD);
  - W-based localparams (N, index width);
  - the default forward table constant and its inverse.
- Sub-module perm3_inv_builder: CLEAR/BUILD FSM, inv/inv_vld storage and dup detection.
- Top level: fwd table, handshake and output register.

Test Plan:
- Reset, then codes 7,6,4,5,1,0,2,3 back-to-back with out_ready=1 -> out_data 0..7 on consecutive cycles, out_err=0, tbl_ok=1.
- out_ready low for 3 cycles while out_valid=1 with code 4 -> out_data=2 held stable, in_ready=0; one pop, then next word issued.
- Write fwd[5]=7 (duplicate of fwd[0]) -> tbl_busy high for 9 cycles, then tbl_ok=0; code 0 -> out_err=1, out_data=0; code 7 -> out_data=0.
- Rewrite fwd[5]=0 -> after 9 cycles tbl_ok=1; code 0 -> out_data=5.
- Second table write at BUILD idx 4 -> build restarts, tbl_busy lasts 9 cycles from the second write, in_ready=0 throughout.
- rst_n pulsed low mid-BUILD with out_valid=1 -> out_valid=0 immediately, default tables restored; code 3 -> out_data=7.
